// File: rtl/fifo_ctrl_sc.sv
// fifo_ctrl_sc: single-clock FIFO pointer/flag controller for ram_memory; define FIFO_CTRL_OVERFLOW_CHK_EN for sticky ovf/udf and sim assertions
module fifo_ctrl_sc #(
  parameter int AWIDTH             = 3,
  parameter int ALMOST_FULL_VALUE  = 6,
  parameter int ALMOST_EMPTY_VALUE = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
  output logic [AWIDTH-1:0] wr_pntr_o,
  output logic [AWIDTH-1:0] rd_pntr_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              ovf_o,
  output logic              udf_o
);
  localparam logic [AWIDTH:0] DEPTH = (AWIDTH+1)'(2**AWIDTH);
  localparam logic [AWIDTH:0] ONE   = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] AF    = (AWIDTH+1)'(ALMOST_FULL_VALUE);
  localparam logic [AWIDTH:0] AE    = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
  logic [AWIDTH:0] wr_q, wr_d, rd_q, rd_d, used_q, used_d;
  logic full_q, empty_q, af_q, ae_q, wr_acc, rd_acc;
  // accept requests against the registered flags and compute next pointers/occupancy
  always_comb begin
    wr_acc = wr_req_i & ~full_q;
    rd_acc = rd_req_i & ~empty_q;
    wr_d   = wr_acc ? wr_q + ONE : wr_q;
    rd_d   = rd_acc ? rd_q + ONE : rd_q;
    used_d = (wr_acc & ~rd_acc) ? used_q + ONE :
             (rd_acc & ~wr_acc) ? used_q - ONE : used_q;
  end
  // state and flags all registered from the next occupancy
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      used_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF == '0);
      ae_q    <= (AE != '0);
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      used_q  <= used_d;
      full_q  <= (used_d == DEPTH);
      empty_q <= (used_d == '0);
      af_q    <= (used_d >= AF);
      ae_q    <= (used_d < AE);
    end
  end
  assign wr_pntr_o      = wr_q[AWIDTH-1:0];
  assign rd_pntr_o      = rd_q[AWIDTH-1:0];
  assign usedw_o        = used_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
`ifdef FIFO_CTRL_OVERFLOW_CHK_EN
  logic ovf_q, udf_q;
  // sticky error flags for requests made against a full/empty FIFO
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr_req_i & full_q);
      udf_q <= udf_q | (rd_req_i & empty_q);
    end
  end
  // occupancy range and flag consistency checks
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      assert (used_q <= DEPTH);
      assert (!(full_q && empty_q));
    end
  end
  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif
endmodule

// File: doc/fifo_ctrl_sc.md
# fifo_ctrl_sc

Single-clock FIFO control stage that sits directly in front of `ram_memory` and drives its pointer and flag inputs. It tracks write/read pointers, occupancy and full/empty/almost flags, so the pair forms a complete synchronous FIFO. `wr_pntr_o`, `rd_pntr_o`, `full_o` and `empty_o` connect straight to `wr_pntr_i`, `rd_pntr_i`, `wr_full_i` and `rd_empty_i` of the memory, with both memory clocks tied to `clk_i`.

## Interface
- `AWIDTH`, 3: address width; FIFO depth = 2**AWIDTH.
- `ALMOST_FULL_VALUE`, 6: `almost_full_o` asserted when `usedw_o >= ALMOST_FULL_VALUE`.
- `ALMOST_EMPTY_VALUE`, 2: `almost_empty_o` asserted when `usedw_o < ALMOST_EMPTY_VALUE`.
- `clk_i`  in  1  single clock; all state on rising edge.
- `srst_i`  in  1  reset, synchronous, active-high.
- `wr_req_i`  in  1  write request; ignored while `full_o`=1.
- `rd_req_i`  in  1  read request; ignored while `empty_o`=1.
- `wr_pntr_o`  out  AWIDTH  RAM write address for the current write.
- `rd_pntr_o`  out  AWIDTH  RAM read address (head of FIFO).
- `full_o`  out  1  FIFO holds 2**AWIDTH words.
- `empty_o`  out  1  FIFO holds 0 words.
- `almost_full_o`  out  1  threshold flag, see parameter.
- `almost_empty_o`  out  1  threshold flag, see parameter.
- `usedw_o`  out  AWIDTH+1  current occupancy, 0..2**AWIDTH.
- `ovf_o`  out  1  sticky: write attempted while full (see Configuration).
- `udf_o`  out  1  sticky: read attempted while empty (see Configuration).

## Operation
- Internal pointers are AWIDTH+1 bits (extra wrap bit); `wr_pntr_o`/`rd_pntr_o` are the low AWIDTH bits.
- Accepted write: `wr_acc = wr_req_i & !full_o`; accepted read: `rd_acc = rd_req_i & !empty_o`. Flags sampled are the registered values of the current cycle.
- `wr_acc` increments write pointer; `rd_acc` increments read pointer; both wrap modulo 2**(AWIDTH+1), so low bits wrap 2**AWIDTH-1 -> 0.
- `usedw` next: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous requests when full: read accepted, write dropped -> usedw -1. When empty: write accepted, read dropped -> usedw +1. Otherwise both accepted, usedw unchanged.
- `full_o` = next usedw == 2**AWIDTH; `empty_o` = next usedw == 0; almost flags from next usedw. All registered — no combinational path from requests to outputs.
- Pointers and usedw never overflow/underflow; rejected requests have no effect on any state except `ovf_o`/`udf_o`.
- Reset values: pointers 0, `usedw_o` 0, `empty_o` 1, `full_o` 0, `almost_empty_o` 1 (if ALMOST_EMPTY_VALUE>0), `almost_full_o` 0 (if ALMOST_FULL_VALUE>0), `ovf_o` 0, `udf_o` 0.
- `srst_i` mid-operation: all state returns to reset values at that edge; requests in the reset cycle are ignored; stored RAM contents are simply abandoned.

## Timing
- All outputs update one edge after the accepting cycle: write accepted at edge N -> `usedw_o`, `empty_o`, `wr_pntr_o` new from N.
- The RAM writes `mem[wr_pntr_o]` at edge N using the pre-increment address — same edge the controller advances.
- Normal-mode read: RAM latches `mem[rd_pntr_o]` at edge N; `q_o` valid after N, one cycle latency from `rd_req_i`.
- Write into empty FIFO: earliest accepted read in the cycle after the write edge (`empty_o` deasserted one cycle after request).
- Back-to-back requests sustain one write and one read per clock.

## Configuration
- `FIFO_CTRL_OVERFLOW_CHK_EN` defined: `ovf_o` set on `wr_req_i & full_o`, `udf_o` set on `rd_req_i & empty_o`; both sticky until `srst_i`; plus simulation assertions that usedw stays in 0..2**AWIDTH and `full_o & empty_o` never both 1.
- Not defined: `ovf_o`/`udf_o` tied to 0, no assertions; all other behaviour identical.

## Test plan
- Reset then idle, AWIDTH=3 -> `empty_o`=1, `full_o`=0, `usedw_o`=0, `almost_empty_o`=1, pointers 0.
- 8 consecutive writes -> `usedw_o` 1..8, `almost_full_o` from usedw=6, `full_o`=1 after 8th, `wr_pntr_o` wraps 7 -> 0.
- Full + 9th write with macro defined -> write dropped, usedw stays 8, `ovf_o`=1 and stays 1 until `srst_i`.
- Simultaneous wr/rd at empty -> usedw 0 -> 1, `rd_pntr_o` unchanged; at full -> usedw 8 -> 7, `wr_pntr_o` unchanged; at usedw=4 -> stays 4, both pointers +1.
- 20 write/read cycles through `ram_memory` with data 0x00..0x13 -> read data matches in order across two pointer wraps.
- `srst_i` asserted at usedw=5 -> next cycle usedw 0, `empty_o`=1, pointers 0, `ovf_o`/`udf_o` 0.
